ttt_turn_controller: RTL and testbench

- Sequencer for the tic-tac-toe game datapath. Consumes decoded keypad events, owns the 9-cell board register, alternates X/O turns and detects win or draw.
- Holds the result for a fixed time, then returns to the main screen.
- Sits between the keypad decoder and the display blocks: 7-segment P1/P2 indicator and dot-matrix board renderer.

---
 rtl/ttt_pkg.sv | 57 +++++
 rtl/ttt_line_checker.sv | 29 ++
 rtl/ttt_turn_controller.sv | 215 +++++++++++++++++++++
 tb/tb_ttt_turn_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// ----------------------------------------------------------------------------
// ttt_pkg
// Shared definitions for the tic-tac-toe turn controller:
//   - FSM state encoding (MAIN, WAIT_KEY, CHECK, RESULT)
//   - keypad code constants and winner codes
//   - the 8 winning lines as triples of 0-based cell indices
//   - helpers that split the 18-bit board into per-player mark planes
// ----------------------------------------------------------------------------
package ttt_pkg;

    // FSM states
    localparam logic [1:0] ST_MAIN     = 2'd0;
    localparam logic [1:0] ST_WAIT_KEY = 2'd1;
    localparam logic [1:0] ST_CHECK    = 2'd2;
    localparam logic [1:0] ST_RESULT   = 2'd3;

    // Keypad codes (1..9 are cells)
    localparam logic [3:0] KEY_START   = 4'hA;
    localparam logic [3:0] KEY_RESTART = 4'hB;
    localparam logic [3:0] KEY_UNDO    = 4'hC;

    // Winner codes
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [3:0] MAX_MOVES = 4'd9;

    // Winning lines, 0-based cell indices; entry 0 is the last group listed.
    localparam logic [7:0][2:0][3:0] WIN_LINES = {
        {4'd2, 4'd4, 4'd6},   // anti-diagonal 3,5,7
        {4'd0, 4'd4, 4'd8},   // diagonal 1,5,9
        {4'd2, 4'd5, 4'd8},   // column 3,6,9
        {4'd1, 4'd4, 4'd7},   // column 2,5,8
        {4'd0, 4'd3, 4'd6},   // column 1,4,7
        {4'd6, 4'd7, 4'd8},   // row 7,8,9
        {4'd3, 4'd4, 4'd5},   // row 4,5,6
        {4'd0, 4'd1, 4'd2}    // row 1,2,3
    };

    // True for keypad codes that address a board cell
    function automatic logic is_cell_key(input logic [3:0] key);
        return (key >= 4'd1) && (key <= 4'd9);
    endfunction

    // Extract one player's 9-bit mark plane (X is the even bit of each cell)
    function automatic logic [8:0] mark_plane(input logic [17:0] brd, input logic o_side);
        logic [8:0] plane;
        plane = 9'd0;
        for (int k = 0; k < 9; k++) begin
            plane[k] = o_side ? brd[2*k+1] : brd[2*k];
        end
        return plane;
    endfunction

endpackage

// File: rtl/ttt_line_checker.sv
// ----------------------------------------------------------------------------
// ttt_line_checker
// Purely combinational: reports whether a 9-bit mark plane completes any of
// the eight winning lines.
// Ports:
//   i_plane  in  9  marks of one player, bit k = cell k+1
//   o_win    out 1  1 when any row, column or diagonal is fully marked
// ----------------------------------------------------------------------------
module ttt_line_checker
    import ttt_pkg::*;
(
    input  logic [8:0] i_plane,
    output logic       o_win
);

    // OR-reduce the AND of the three cells of every line
    always_comb begin
        o_win = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (i_plane[WIN_LINES[l][0]] && i_plane[WIN_LINES[l][1]] &&
                i_plane[WIN_LINES[l][2]]) begin
                o_win = 1'b1;
            end else begin
                o_win = o_win;
            end
        end
    end

endmodule

// File: rtl/ttt_turn_controller.sv
// ----------------------------------------------------------------------------
// ttt_turn_controller
// Game sequencer between the keypad decoder and the display blocks. Owns the
// board register, alternates X/O, detects win/draw and holds the result for
// HOLD_CYCLES clocks before returning to the title screen.
// Optional build macro: TTT_UNDO_EN enables a single-level undo on key 4'hC.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   key_data[3:0]   keypad code, qualified by key_valid
//   key_valid       one-cycle strobe per keypress
//   board[17:0]     cell k at [2k-1:2k-2]; even bit = X, odd bit = O
//   is_main         1 on the title screen
//   is_turn_o       0 = X to move, 1 = O to move
//   winner[1:0]     00 none, 01 X, 10 O, 11 draw
//   game_over       1 while the result is shown
//   move_err        one-cycle pulse on a rejected key
// ----------------------------------------------------------------------------
module ttt_turn_controller
    import ttt_pkg::*;
#(
    parameter int HOLD_CYCLES = 25000000,
    parameter int HOLD_W      = 25
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_data,
    input  logic        key_valid,
    output logic [17:0] board,
    output logic        is_main,
    output logic        is_turn_o,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic        move_err
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [1:0]        r_state,      w_state_nxt;
    logic [17:0]       r_board,      w_board_nxt;
    logic              r_is_turn_o,  w_is_turn_o_nxt;
    logic [1:0]        r_winner,     w_winner_nxt;
    logic              r_game_over,  w_game_over_nxt;
    logic              r_move_err,   w_move_err_nxt;
    logic              r_is_main,    w_is_main_nxt;
    logic [3:0]        r_move_count, w_move_count_nxt;
    logic [HOLD_W-1:0] r_hold,       w_hold_nxt;
`ifdef TTT_UNDO_EN
    logic [3:0]        r_last_cell,  w_last_cell_nxt;
    logic              r_undo_tok,   w_undo_tok_nxt;
`endif

    logic [3:0] w_cell_idx;
    logic [1:0] w_cell_bits;
    logic [4:0] w_mark_bit;
    logic       w_restart;
    logic       w_win;

    assign w_cell_idx  = key_data - 4'd1;
    assign w_cell_bits = r_board[{w_cell_idx, 1'b0} +: 2];
    assign w_mark_bit  = {w_cell_idx, 1'b0} + {4'd0, r_is_turn_o};
    assign w_restart   = key_valid && (key_data == KEY_RESTART) && (r_state != ST_MAIN);

    // The checker only ever sees the plane of the player who just moved
    ttt_line_checker u_line_checker (
        .i_plane (mark_plane(r_board, r_is_turn_o)),
        .o_win   (w_win)
    );

    // Next-state and next-output decode; RESTART overrides every other event
    always_comb begin
        w_state_nxt      = r_state;
        w_board_nxt      = r_board;
        w_is_turn_o_nxt  = r_is_turn_o;
        w_winner_nxt     = r_winner;
        w_game_over_nxt  = r_game_over;
        w_move_err_nxt   = 1'b0;
        w_move_count_nxt = r_move_count;
        w_hold_nxt       = r_hold;
`ifdef TTT_UNDO_EN
        w_last_cell_nxt  = r_last_cell;
        w_undo_tok_nxt   = r_undo_tok;
`endif
        if (w_restart) begin
            w_state_nxt      = ST_MAIN;
            w_board_nxt      = 18'd0;
            w_is_turn_o_nxt  = 1'b0;
            w_winner_nxt     = WIN_NONE;
            w_game_over_nxt  = 1'b0;
            w_move_count_nxt = 4'd0;
            w_hold_nxt       = {HOLD_W{1'b0}};
`ifdef TTT_UNDO_EN
            w_undo_tok_nxt   = 1'b0;
`endif
        end else begin
            case (r_state)
                ST_MAIN: begin
                    if (key_valid && (key_data == KEY_START)) begin
                        w_state_nxt      = ST_WAIT_KEY;
                        w_board_nxt      = 18'd0;
                        w_is_turn_o_nxt  = 1'b0;
                        w_winner_nxt     = WIN_NONE;
                        w_move_count_nxt = 4'd0;
`ifdef TTT_UNDO_EN
                        w_undo_tok_nxt   = 1'b0;
`endif
                    end else begin
                        w_state_nxt = ST_MAIN;
                    end
                end
                ST_WAIT_KEY: begin
                    if (key_valid && is_cell_key(key_data) && (w_cell_bits == 2'b00)) begin
                        w_board_nxt[w_mark_bit] = 1'b1;
                        w_move_count_nxt = (r_move_count < MAX_MOVES) ?
                                           (r_move_count + 4'd1) : r_move_count;
                        w_state_nxt      = ST_CHECK;
`ifdef TTT_UNDO_EN
                        w_last_cell_nxt  = w_cell_idx;
                        w_undo_tok_nxt   = 1'b1;
`endif
`ifdef TTT_UNDO_EN
                    end else if (key_valid && (key_data == KEY_UNDO) && r_undo_tok) begin
                        w_board_nxt[{r_last_cell, 1'b0} +: 2] = 2'b00;
                        w_move_count_nxt = (r_move_count != 4'd0) ?
                                           (r_move_count - 4'd1) : r_move_count;
                        w_is_turn_o_nxt  = ~r_is_turn_o;
                        w_undo_tok_nxt   = 1'b0;
`endif
                    end else if (key_valid) begin
                        // occupied cell, key 0, START, or any code above RESTART
                        w_move_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT_KEY;
                    end
                end
                ST_CHECK: begin
                    if (w_win) begin
                        w_winner_nxt    = r_is_turn_o ? WIN_O : WIN_X;
                        w_game_over_nxt = 1'b1;
                        w_hold_nxt      = {HOLD_W{1'b0}};
                        w_state_nxt     = ST_RESULT;
                    end else if (r_move_count == MAX_MOVES) begin
                        w_winner_nxt    = WIN_DRAW;
                        w_game_over_nxt = 1'b1;
                        w_hold_nxt      = {HOLD_W{1'b0}};
                        w_state_nxt     = ST_RESULT;
                    end else begin
                        w_is_turn_o_nxt = ~r_is_turn_o;
                        w_state_nxt     = ST_WAIT_KEY;
                    end
                end
                ST_RESULT: begin
                    if (r_hold == HOLD_LAST) begin
                        w_state_nxt     = ST_MAIN;
                        w_winner_nxt    = WIN_NONE;
                        w_game_over_nxt = 1'b0;
                        w_hold_nxt      = {HOLD_W{1'b0}};
                    end else begin
                        w_hold_nxt = r_hold + HOLD_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_MAIN;
                end
            endcase
        end
        w_is_main_nxt = (w_state_nxt == ST_MAIN);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_MAIN;
            r_board      <= 18'd0;
            r_is_turn_o  <= 1'b0;
            r_winner     <= WIN_NONE;
            r_game_over  <= 1'b0;
            r_move_err   <= 1'b0;
            r_is_main    <= 1'b1;
            r_move_count <= 4'd0;
            r_hold       <= {HOLD_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_board      <= w_board_nxt;
            r_is_turn_o  <= w_is_turn_o_nxt;
            r_winner     <= w_winner_nxt;
            r_game_over  <= w_game_over_nxt;
            r_move_err   <= w_move_err_nxt;
            r_is_main    <= w_is_main_nxt;
            r_move_count <= w_move_count_nxt;
            r_hold       <= w_hold_nxt;
        end
    end

`ifdef TTT_UNDO_EN
    // Single-level undo bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_cell <= 4'd0;
            r_undo_tok  <= 1'b0;
        end else begin
            r_last_cell <= w_last_cell_nxt;
            r_undo_tok  <= w_undo_tok_nxt;
        end
    end
`endif

    assign board     = r_board;
    assign is_main   = r_is_main;
    assign is_turn_o = r_is_turn_o;
    assign winner    = r_winner;
    assign game_over = r_game_over;
    assign move_err  = r_move_err;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// ----------------------------------------------------------------------------
// tb_ttt_turn_controller
// Game-level reference model feeds a queue of expected output vectors
// {board, is_turn_o, winner, game_over, is_main, move_err}; each scenario task
// pops and compares after every clock edge. Idle cycles in sequences are 16.
// ----------------------------------------------------------------------------
module tb_ttt_turn_controller;

    localparam int HOLD = 16;
    localparam int IDLE = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_data;
    logic        key_valid;
    logic [17:0] board;
    logic        is_main, is_turn_o, game_over, move_err;
    logic [1:0]  winner;
    logic [23:0] obs;

    always #5 clk = ~clk;

    ttt_turn_controller #(.HOLD_CYCLES(HOLD), .HOLD_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_data  (key_data),
        .key_valid (key_valid),
        .board     (board),
        .is_main   (is_main),
        .is_turn_o (is_turn_o),
        .winner    (winner),
        .game_over (game_over),
        .move_err  (move_err)
    );

    assign obs = {board, is_turn_o, winner, game_over, is_main, move_err};

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] exp_q[$];

    // Reference model: phase 0 main, 1 wait, 2 check, 3 result; cell 1 = X, 2 = O
    int m_cells [1:9];
    int m_phase, m_turn, m_count, m_winner, m_hold, m_err, m_tok, m_last;
    int lines [0:7][0:2] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                             '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

    function automatic logic [17:0] m_board();
        logic [17:0] b;
        b = 18'd0;
        for (int k = 1; k <= 9; k++) begin
            if (m_cells[k] == 1) b[2*k-2] = 1'b1;
            if (m_cells[k] == 2) b[2*k-1] = 1'b1;
        end
        return b;
    endfunction

    function automatic bit m_wins(int mark);
        for (int l = 0; l < 8; l++)
            if (m_cells[lines[l][0]] == mark && m_cells[lines[l][1]] == mark &&
                m_cells[lines[l][2]] == mark) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_clear_game();
        for (int k = 1; k <= 9; k++) m_cells[k] = 0;
        m_turn = 0; m_count = 0; m_winner = 0; m_hold = 0; m_tok = 0;
    endfunction

    function automatic void m_push();
        logic [1:0] w;
        w = m_winner[1:0];
        exp_q.push_back({m_board(), m_turn[0], w, (m_phase == 3), (m_phase == 0), m_err[0]});
    endfunction

    function automatic void model_reset();
        m_clear_game();
        m_phase = 0; m_err = 0; m_last = 1;
        m_push();
    endfunction

    function automatic void model_step(bit v, int k);
        m_err = 0;
        if (v && k == 11 && m_phase != 0) begin
            m_clear_game();
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (v && k == 10) begin m_clear_game(); m_phase = 1; end
                1: begin
                    if (v && k >= 1 && k <= 9 && m_cells[k] == 0) begin
                        m_cells[k] = m_turn + 1; m_count++; m_last = k; m_tok = 1; m_phase = 2;
`ifdef TTT_UNDO_EN
                    end else if (v && k == 12 && m_tok == 1) begin
                        m_cells[m_last] = 0; m_count--; m_turn = 1 - m_turn; m_tok = 0;
`endif
                    end else if (v) begin
                        m_err = 1;
                    end
                end
                2: begin
                    if (m_wins(m_turn + 1)) begin
                        m_winner = (m_turn == 1) ? 2 : 1; m_phase = 3; m_hold = 0;
                    end else if (m_count == 9) begin
                        m_winner = 3; m_phase = 3; m_hold = 0;
                    end else begin
                        m_turn = 1 - m_turn; m_phase = 1;
                    end
                end
                default: begin
                    if (m_hold == HOLD - 1) begin m_phase = 0; m_winner = 0; m_hold = 0; end
                    else m_hold++;
                end
            endcase
        end
        m_push();
    endfunction

    // Drive one cycle of stimulus and advance the model to the same edge
    task automatic step(input int s);
        key_valid = (s < IDLE);
        key_data  = s[3:0];
        model_step(s < IDLE, s);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_data  = 4'd0;
    endtask

    task automatic test_reset();
        logic [23:0] e;
        rst = 1'b1; key_valid = 1'b0; key_data = 4'd0;
        model_reset();
        #2;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL reset: got %h expected %h", obs, e); end
        @(posedge clk); #1; rst = 1'b0;
        step(IDLE);
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", obs, e); end
    endtask

    task automatic test_main_ignore();
        int seq[$] = '{1, 0, 11, 12, 9};
        logic [23:0] e;
        foreach (seq[i]) begin
            step(seq[i]);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL main_ignore[%0d]: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_x_win();
        int seq[$] = '{10, 1, IDLE, 4, IDLE, 2, IDLE, 5, IDLE, 3, IDLE};
        logic [23:0] e;
        foreach (seq[i]) begin
            step(seq[i]);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL x_win[%0d]: got %h expected %h", i, obs, e); end
        end
        n_checks++;
        if (board !== 18'h00295 || winner !== 2'b01 || game_over !== 1'b1) begin
            n_fail++; $display("FAIL x_win_final: got %h/%b/%b expected 00295/01/1", board, winner, game_over);
        end
        for (int i = 0; i < HOLD; i++) begin
            step(i == 3 ? 5 : IDLE);  // a cell key while showing the result is ignored
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL x_win_hold[%0d]: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_occupied();
        int seq[$] = '{10, 1, IDLE, 1, IDLE, 0, 13, 10, IDLE, 11, IDLE};
        logic [23:0] e;
        foreach (seq[i]) begin
            step(seq[i]);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL occupied[%0d]: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_draw_then_restart();
        int seq[$] = '{10, 1, IDLE, 2, IDLE, 3, IDLE, 5, IDLE, 4, IDLE, 6, IDLE,
                       8, IDLE, 7, IDLE, 9, IDLE, IDLE, IDLE};
        logic [23:0] e;
        foreach (seq[i]) begin
            step(seq[i]);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL draw[%0d]: got %h expected %h", i, obs, e); end
        end
        n_checks++;
        if (dut.r_move_count !== 4'(m_count) || winner !== 2'b11) begin
            n_fail++; $display("FAIL draw_count: got %0d/%b expected %0d/11", dut.r_move_count, winner, m_count);
        end
        step(11);  // RESTART while the result is shown
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL restart_result: got %h expected %h", obs, e); end
    endtask

    task automatic test_restart_midgame();
        int seq[$] = '{10, 1, IDLE, 5, IDLE, 9, IDLE, 3, IDLE, 11, IDLE, 10, 2, 11, IDLE};
        logic [23:0] e;
        foreach (seq[i]) begin
            step(seq[i]);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL restart_mid[%0d]: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_back_to_back();
        int seq[$] = '{10, 1, 2, 2, 3, 3, 4, 5, 7, 7, 9, 11};
        logic [23:0] e;
        foreach (seq[i]) begin
            step(seq[i]);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_undo();
        int seq[$] = '{10, 5, IDLE, 12, 12, IDLE, 4, IDLE, 12, 11};
        logic [23:0] e;
        foreach (seq[i]) begin
            step(seq[i]);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL undo[%0d]: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_async_reset();
        int seq[$] = '{10, 7, IDLE, 3, IDLE};
        logic [23:0] e;
        foreach (seq[i]) begin
            step(seq[i]);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL async_pre[%0d]: got %h expected %h", i, obs, e); end
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL async_reset: got %h expected %h", obs, e); end
        @(negedge clk); #1;
        rst = 1'b0;
        step(IDLE);
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL async_post: got %h expected %h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_main_ignore();
        test_x_win();
        test_occupied();
        test_draw_then_restart();
        test_restart_midgame();
        test_back_to_back();
        test_undo();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
